// File: rtl/shift_rotate_pkg.sv
// Shared types for the shift/rotate register: operation codes and controller states.
package shift_rotate_pkg;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'd0,
    OP_SLL     = 3'd1,
    OP_SRL     = 3'd2,
    OP_SRA     = 3'd3,
    OP_ROL     = 3'd4,
    OP_ROR     = 3'd5,
    OP_SHL_SER = 3'd6,
    OP_SHR_SER = 3'd7
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sru_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the shift/rotate register.
// out_bit is the bit that leaves the word on this step.
module shift_step
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  shift_op_e        op,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  // LOAD never reaches this path while shifting, so it just holds q.
  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (op)
      OP_SLL: begin
        next_q  = {q[WIDTH-2:0], 1'b0};
        out_bit = q[WIDTH-1];
      end
      OP_SRL: begin
        next_q  = {1'b0, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_SRA: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_SHL_SER: begin
        next_q  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
      end
      OP_SHR_SER: begin
        next_q  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate register with start/busy/done handshake.
// One bit moves per clock; the step itself lives in shift_step.
module shift_rotate_unit
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             carry_out
);

  sru_state_e       state_q, state_d;
  shift_op_e        op_q, op_d, op_req;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_d;
  logic             carry_d;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign op_req = shift_op_e'(op);

  // The step uses the latched op so mid-shift op changes have no effect.
  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q        (q),
    .op       (op_q),
    .serial_in(serial_in),
    .next_q   (step_q),
    .out_bit  (step_bit)
  );

  // Next-state and datapath; a zero amount finishes without entering SHIFT.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q;
    carry_d = carry_out;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (op_req == OP_LOAD) begin
            q_d     = data_in;
            carry_d = 1'b0;
            state_d = ST_DONE;
          end else if (amount == '0) begin
            state_d = ST_DONE;
          end else begin
            op_d    = op_req;
            cnt_d   = amount;
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        q_d     = step_q;
        carry_d = step_bit;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      cnt_q     <= '0;
      q         <= '0;
      carry_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      q         <= q_d;
      carry_out <= carry_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench: directed scenarios plus random traffic against an arithmetic model.
module tb_shift_rotate_unit;
  import shift_rotate_pkg::*;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH + 1);
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = 1 << (WIDTH - 1);

  logic             clock = 1'b0;
  logic             resetn;
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             carry_out;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  int m_q;
  int m_rem;
  int m_op;
  bit m_carry;
  bit m_done;

  shift_rotate_unit #(
    .WIDTH(WIDTH)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .data_in  (data_in),
    .serial_in(serial_in),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .carry_out(carry_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level arithmetic view of one step: multiply/divide by two plus the fill bit.
  function automatic int model_step(input int o, input int v, input int sin, output bit co);
    int r;
    r  = v;
    co = 1'b0;
    case (o)
      1: begin co = (v >= HALF); r = (v * 2) % MOD; end
      2: begin co = v % 2; r = v / 2; end
      3: begin co = v % 2; r = v / 2 + ((v >= HALF) ? HALF : 0); end
      4: begin co = (v >= HALF); r = (v * 2) % MOD + v / HALF; end
      5: begin co = v % 2; r = v / 2 + (v % 2) * HALF; end
      6: begin co = (v >= HALF); r = (v * 2) % MOD + sin; end
      7: begin co = v % 2; r = v / 2 + sin * HALF; end
      default: r = v;
    endcase
    return r;
  endfunction

  // Reference model: remaining step count plus a one-cycle done flag.
  always @(posedge clock or negedge resetn) begin
    bit co;
    if (!resetn) begin
      m_q = 0; m_rem = 0; m_op = 0; m_carry = 1'b0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_q     = model_step(m_op, m_q, int'(serial_in), co);
      m_carry = co;
      m_rem   = m_rem - 1;
      m_done  = (m_rem == 0);
    end else if (start) begin
      if (int'(op) == 0) begin
        m_q = int'(data_in); m_carry = 1'b0; m_done = 1'b1;
      end else if (int'(amount) == 0) begin
        m_done = 1'b1;
      end else begin
        m_op = int'(op); m_rem = int'(amount); m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(posedge clock) begin
    #1;
    if (cmp_en) begin
      check("cyc_q", q, m_q);
      check("cyc_busy", busy, m_rem > 0);
      check("cyc_done", done, m_done);
      check("cyc_carry", carry_out, m_carry);
    end
  end

  // Issue one request; returns just after its accept edge.
  task automatic apply_stimulus(input int o, input int amt, input int data, input bit sin);
    @(negedge clock);
    op        = 3'(o);
    amount    = AMT_W'(amt);
    data_in   = WIDTH'(data);
    serial_in = sin;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic check_output(input string name, input int exp_q, input bit exp_carry);
    check({name, "_q"}, q, exp_q);
    check({name, "_carry"}, carry_out, exp_carry);
  endtask

  initial begin
    bit co;
    int r;
    resetn = 1'b0; start = 1'b0; op = '0; amount = '0; data_in = '0; serial_in = 1'b0;

    r = model_step(5, 'hA5, 0, co); check("pin_ror", r, 'hD2); check("pin_ror_c", co, 1);
    r = model_step(3, 'h96, 0, co); check("pin_sra", r, 'hCB); check("pin_sra_c", co, 0);
    r = model_step(6, 'h80, 1, co); check("pin_shl", r, 'h01); check("pin_shl_c", co, 1);

    #2;
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Reset in the middle of a rotate
    apply_stimulus(0, 0, 'h81, 0);
    apply_stimulus(4, 5, 0, 0);
    repeat (2) begin @(posedge clock); #1; end
    @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_q", q, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_carry", carry_out, 0);
    @(negedge clock);
    resetn = 1'b1;

    apply_stimulus(0, 0, 'hA5, 0);
    check_output("load", 'hA5, 0);
    check("load_done", done, 1);
    @(posedge clock); #1;
    check("load_done_once", done, 0);

    apply_stimulus(5, 3, 0, 0);
    check("ror_busy", busy, 1);
    wait_done(10);
    check_output("ror", 'hB4, 1);

    apply_stimulus(0, 0, 'h96, 0);
    apply_stimulus(3, 2, 0, 0);
    @(negedge clock);
    op = 3'd0; data_in = 8'h00; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(10);
    check_output("sra", 'hE5, 1);

    apply_stimulus(1, 0, 0, 0);
    check("sll0_done", done, 1);
    check_output("sll0", 'hE5, 1);
    apply_stimulus(1, 9, 0, 0);
    wait_done(20);
    check_output("sll9", 'h00, 0);

    apply_stimulus(6, 8, 0, 1);
    wait_done(20);
    check_output("shlser", 'hFF, 0);
    apply_stimulus(0, 0, 'h3C, 0);
    check("b2b_q", q, 'h3C);
    check("b2b_done", done, 1);

    // Random traffic, including starts while busy and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      start     = ($urandom % 4) == 0;
      op        = 3'($urandom % 8);
      amount    = (($urandom % 8) == 0) ? AMT_W'($urandom % (1 << AMT_W)) : AMT_W'($urandom % 6);
      data_in   = WIDTH'($urandom);
      serial_in = 1'($urandom);
      if (($urandom % 400) == 0) begin
        #2 resetn = 1'b0;
        #1 resetn = 1'b1;
      end
    end
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
